// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: maps MIDI note-on/off events from the framer onto
// NUM_VOICES slots (match, then free, then oldest steal) with a retrigger gap.
module midi_voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int CHANNEL    = 0,
  parameter bit OMNI       = 1'b1,
  parameter int RETRIG_GAP = 400
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    midi_event_valid,
  input  logic [7:0]              midi_command,
  input  logic [7:0]              midi_parameter_1,
  input  logic [7:0]              midi_parameter_2,
  output logic                    midi_data_ack,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_velocity
);
  localparam int IW = $clog2(NUM_VOICES);
  localparam int CW = $clog2(RETRIG_GAP + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VOICES - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(RETRIG_GAP - 1);
  localparam logic [3:0]    CHAN     = 4'(CHANNEL);

  typedef enum logic [2:0] {IDLE, SCAN, RETRIG, COMMIT, ACK, WAITLOW} state_t;
  typedef enum logic [1:0] {EV_IGNORE, EV_NOTE_ON, EV_NOTE_OFF, EV_ALL_OFF} event_t;

  state_t state, state_nx;
  event_t ev_kind, ev_decoded;
  logic [7:0] ev_p1;
  logic [6:0] ev_vel;

  logic [NUM_VOICES-1:0] gate_q;
  logic [6:0] note_q [NUM_VOICES];
  logic [6:0] vel_q  [NUM_VOICES];
  logic [7:0] age_q  [NUM_VOICES];

  logic [IW-1:0] scan_idx, match_idx, free_idx, old_idx, target_idx;
  logic          match_found, free_found;
  logic [7:0]    old_age;
  logic [CW-1:0] gap_cnt;

  logic [IW-1:0] match_idx_nx, free_idx_nx, old_idx_nx, target_nx;
  logic          match_found_nx, free_found_nx, target_gated;
  logic [7:0]    old_age_nx;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    ev_decoded = EV_IGNORE;
    if (OMNI || midi_command[3:0] == CHAN) begin
      case (midi_command[7:4])
        4'h9:    ev_decoded = (midi_parameter_2 != 8'd0) ? EV_NOTE_ON : EV_NOTE_OFF;
        4'h8:    ev_decoded = EV_NOTE_OFF;
        4'hB:    if (midi_parameter_1 == 8'd123) ev_decoded = EV_ALL_OFF;
        default: ev_decoded = EV_IGNORE;
      endcase
    end
  end

  // Running search over the slot under scan; target is valid on the last scan cycle.
  always_comb begin
    match_found_nx = match_found;
    match_idx_nx   = match_idx;
    free_found_nx  = free_found;
    free_idx_nx    = free_idx;
    old_idx_nx     = old_idx;
    old_age_nx     = old_age;
    if (!match_found && gate_q[scan_idx] && {1'b0, note_q[scan_idx]} == ev_p1) begin
      match_found_nx = 1'b1;
      match_idx_nx   = scan_idx;
    end
    if (!free_found && !gate_q[scan_idx]) begin
      free_found_nx = 1'b1;
      free_idx_nx   = scan_idx;
    end
    if (age_q[scan_idx] > old_age) begin
      old_age_nx = age_q[scan_idx];
      old_idx_nx = scan_idx;
    end
    if (match_found_nx)     target_nx = match_idx_nx;
    else if (free_found_nx) target_nx = free_idx_nx;
    else                    target_nx = old_idx_nx;
    target_gated = gate_q[target_nx];
  end

  always_comb begin
    state_nx      = state;
    midi_data_ack = 1'b0;
    case (state)
      IDLE:    if (midi_event_valid)
                 state_nx = (ev_decoded == EV_NOTE_ON || ev_decoded == EV_NOTE_OFF) ? SCAN : COMMIT;
      SCAN:    if (scan_idx == LAST_IDX)
                 state_nx = (ev_kind == EV_NOTE_ON && target_gated) ? RETRIG : COMMIT;
      RETRIG:  if (gap_cnt == GAP_END) state_nx = COMMIT;
      COMMIT:  state_nx = ACK;
      ACK: begin
        midi_data_ack = 1'b1;
        state_nx      = WAITLOW;
      end
      WAITLOW: if (!midi_event_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the slot table is reset element by element because its contents drive outputs that must read 0 after reset.
      for (int k = 0; k < NUM_VOICES; k++) begin
        note_q[k] <= '0;
        vel_q[k]  <= '0;
        age_q[k]  <= '0;
      end
      gate_q      <= '0;
      ev_kind     <= EV_IGNORE;
      ev_p1       <= '0;
      ev_vel      <= '0;
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
      target_idx  <= '0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (midi_event_valid) begin
          ev_kind     <= ev_decoded;
          ev_p1       <= midi_parameter_1;
          ev_vel      <= midi_parameter_2[6:0];
          scan_idx    <= '0;
          match_found <= 1'b0;
          match_idx   <= '0;
          free_found  <= 1'b0;
          free_idx    <= '0;
          old_idx     <= '0;
          old_age     <= '0;
        end
        SCAN: begin
          match_found <= match_found_nx;
          match_idx   <= match_idx_nx;
          free_found  <= free_found_nx;
          free_idx    <= free_idx_nx;
          old_idx     <= old_idx_nx;
          old_age     <= old_age_nx;
          target_idx  <= target_nx;
          scan_idx    <= scan_idx + 1'b1;
          gap_cnt     <= '0;
        end
        RETRIG: begin
          // Writing 0 from the first gap cycle keeps the gate visibly low for RETRIG_GAP cycles.
          gate_q[target_idx] <= 1'b0;
          gap_cnt            <= gap_cnt + 1'b1;
        end
        COMMIT: case (ev_kind)
          EV_NOTE_ON: for (int k = 0; k < NUM_VOICES; k++) begin
            if (IW'(k) == target_idx) begin
              gate_q[k] <= 1'b1;
              note_q[k] <= ev_p1[6:0];
              vel_q[k]  <= ev_vel;
              age_q[k]  <= '0;
            end else if (age_q[k] != 8'hFF) begin
              age_q[k] <= age_q[k] + 8'd1;
            end
          end
          EV_NOTE_OFF: for (int k = 0; k < NUM_VOICES; k++) begin
            if (gate_q[k] && {1'b0, note_q[k]} == ev_p1) gate_q[k] <= 1'b0;
          end
          EV_ALL_OFF: gate_q <= '0;
          default: ;
        endcase
        default: ;
      endcase
    end
  end

  assign voice_gate = gate_q;
  for (genvar k = 0; k < NUM_VOICES; k++) begin : g_out
    assign voice_note[7*k +: 7]     = note_q[k];
    assign voice_velocity[7*k +: 7] = vel_q[k];
  end
endmodule

// File: doc/midi_voice_allocator.md
Name: midi_voice_allocator

Overview:
- Polyphonic voice allocator. Sits directly downstream of the MIDI framer and consumes its complete events through the valid/ack handshake.
- Maps note-on/note-off events onto a pool of NUM_VOICES voice slots. Drives per-slot gate, note and velocity outputs to the voice bank, whose per-slot tone_freq mux is external to this block.
- Replaces the fixed one-voice-per-note wiring, so a small voice bank can play any MIDI note.

Parameters:
- NUM_VOICES, 8, number of voice slots (2..16).
- CHANNEL, 0, MIDI channel (0..15) accepted when OMNI=0.
- OMNI, 1, 1 = accept all channels.
- RETRIG_GAP, 400, clk cycles a re-assigned, still-gated slot is held low before re-gating; must exceed one sample_clk period.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- midi_event_valid  in  1  framer has a complete event.
- midi_command  in  8  status byte.
- midi_parameter_1  in  8  note number or controller number.
- midi_parameter_2  in  8  velocity or controller value.
- midi_data_ack  out  1  one-cycle pulse: event consumed.
- voice_gate  out  NUM_VOICES  per-slot gate.
- voice_note  out  7*NUM_VOICES  slot k at bits [7k+6:7k].
- voice_velocity  out  7*NUM_VOICES  slot k at bits [7k+6:7k].

Behaviour:
- Reset: all outputs 0; all ages 0; FSM to IDLE. Reset mid-event aborts the event with no ack and no table change.
- Accept rule: the event is captured only in IDLE while midi_event_valid=1. Capture all three bytes in that cycle; later input changes are ignored.
- Command decode uses cmd[7:4]. Channel match is OMNI or cmd[3:0]==CHANNEL.
  - 0x9 with vel≠0 → NOTE_ON.
  - 0x8, or 0x9 with vel=0 → NOTE_OFF.
  - 0xB with p1==123 → ALL_OFF.
  - Anything else, or a channel mismatch → IGNORE.
- FSM states: IDLE → SCAN → (RETRIG) → COMMIT → ACK → WAITLOW → IDLE.
- SCAN: examines one slot per cycle, index 0..NUM_VOICES-1, so it lasts NUM_VOICES cycles. It records:
  - the first slot with gate=1 and note==p1 (match);
  - the first slot with gate=0 (free);
  - the slot with the greatest age, lowest index on ties (oldest).
  - IGNORE and ALL_OFF skip SCAN and go straight to COMMIT.
- NOTE_ON target priority: match, then free, then oldest (steal).
  - Target gate=1 (retrigger or steal): enter RETRIG, force that gate to 0 for exactly RETRIG_GAP cycles, then COMMIT.
  - Target gate=0: go straight to COMMIT.
- COMMIT (1 cycle):
  - NOTE_ON: target gate←1, note←p1[6:0], vel←p2[6:0], age←0; every other slot's age increments, 8-bit, saturating at 255.
  - NOTE_OFF: every slot with gate=1 and note==p1 gets gate←0. Note and velocity are retained for release. No match → no change.
  - ALL_OFF: all gates←0.
- ACK: midi_data_ack=1 for exactly one cycle.
- WAITLOW: hold until midi_event_valid=0, then IDLE. This prevents double-consuming an event the framer has not yet dropped.
- Latency, valid high at cycle 0:
  - NOTE_ON/NOTE_OFF: ack at cycle NUM_VOICES+2, plus RETRIG_GAP when retriggering.
  - IGNORE/ALL_OFF: ack at cycle 2.
- Gate outputs are registered and change only in COMMIT, or at RETRIG entry.

Test Plan:
1. Reset, then NOTE_ON 0x90/60/100 → ack at cycle 10 (NUM_VOICES=8); gate=0x01; note0=60; vel0=100; ack high exactly 1 cycle.
2. NOTE_ON 60, 64, 67 in turn, then 0x80/64/0 → gates 0x07 then 0x05; note1 still 64.
3. Nine distinct NOTE_ONs 40..48 → 9th (48) steals slot 0 (note 40, oldest). Gate0 is low for exactly 400 cycles, then high with note 48; ack at cycle 410.
4. NOTE_ON 60, then 0x90/60/0 → slot 0 gate cleared. Then NOTE_ON 60 twice → second reuses slot 0 via the RETRIG gap; no second slot allocated.
5. OMNI=0, CHANNEL=2: 0x91/60/100 → acked at cycle 2, gates unchanged; 0x92/60/100 → slot 0 gated. Then 0xB2/123/0 → all gates 0.
6. Hold midi_event_valid high for 30 cycles after ack → exactly one ack. Assert rst during SCAN → no ack, gates 0, next event handled normally.
